hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Parametrised hazard and pipeline-control unit for the 5-stage RISC-V core, the successor to the current hazard_unit.
- Generates E-stage forwarding selects.
- Tracks pending load writebacks in a per-register countdown scoreboard, so load-use latency is configurable rather than fixed at one cycle.
- Flushes wrong-path F/D/E latches when a branch resolves taken in M.
- Keeps saturating stall and flush counters for performance analysis.

Parameters:
ADDR_W, 5, register address width; register count is 2**ADDR_W.
ALU_SRC_SEL_W, 2, forwarding select width.
LOAD_LAT, 1, stall cycles needed by a load-use pair. Legal range 1..7. Use 1 for the M-stage memory, 2 when load data is usable only from W.
CNT_W, 32, performance counter width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
rf_src0_d_i  in  ADDR_W  source 0 of the instruction in D
rf_src1_d_i  in  ADDR_W  source 1 of the instruction in D
has_imm_d_i  in  1  D instruction uses an immediate, so src1 is unused
rf_dst_d_i  in  ADDR_W  destination of the D instruction
rf_we_d_i  in  1  D instruction writes the register file
mem2rf_d_i  in  1  D instruction is a load
rf_src0_e_i  in  ADDR_W  source 0 of the instruction in E
rf_src1_e_i  in  ADDR_W  source 1 of the instruction in E
rf_dst_m_i  in  ADDR_W  destination of the instruction in M
rf_we_m_i  in  1  M instruction writes the register file
rf_dst_w_i  in  ADDR_W  destination of the instruction in W
rf_we_w_i  in  1  W instruction writes the register file
pc_src_m_i  in  1  branch taken, resolved in M
alu_src0_sel_o  out  ALU_SRC_SEL_W  E operand 0 select
alu_src1_sel_o  out  ALU_SRC_SEL_W  E operand 1 select
latch_en_f_o  out  1  enable for the PC and the F/D latch
latch_clear_f_o  out  1  clear the F/D latch
latch_clear_d_o  out  1  clear the D/E latch
latch_clear_e_o  out  1  clear the E/M latch
stall_cnt_o  out  CNT_W  count of load-use stall cycles
flush_cnt_o  out  CNT_W  count of flush cycles

Behaviour:
- Forwarding (combinational), evaluated per source:
  - Select 1 (from M) when src != 0 and rf_we_m_i and src == rf_dst_m_i.
  - Otherwise select 2 (from W) when src != 0 and rf_we_w_i and src == rf_dst_w_i.
  - Otherwise select 0 (register file). Select 3 is reserved and never driven.
  - M has priority over W.
- Scoreboard:
  - One timer per register, width clog2(LOAD_LAT+1); register 0 has no timer and always reads 0.
  - Every cycle, each nonzero timer decrements by 1.
  - issue = !stall && !pc_src_m_i.
  - On issue with rf_we_d_i && mem2rf_d_i && rf_dst_d_i != 0, timer[rf_dst_d_i] is loaded with LOAD_LAT. The load overrides the decrement of that entry.
- E-load tracker:
  - e_load_vld/e_load_dst register whether the instruction now in E is a scoreboarded load, and its destination.
  - Loaded on issue; set to 0 when the cycle does not issue (stall or flush inserts a bubble).
- Stall (combinational) is asserted when either of these holds:
  - rf_src0_d_i != 0 and timer[rf_src0_d_i] != 0;
  - !has_imm_d_i and rf_src1_d_i != 0 and timer[rf_src1_d_i] != 0.
- Stall without flush:
  - latch_en_f_o=0, latch_clear_d_o=1.
  - latch_clear_f_o=0, latch_clear_e_o=0.
  - stall_cnt_o increments.
- Flush (pc_src_m_i=1):
  - latch_en_f_o=1, latch_clear_f_o=1, latch_clear_d_o=1, latch_clear_e_o=1.
  - Flush overrides stall; the cycle is not counted as a stall.
  - No issue occurs, so no timer is loaded.
  - If e_load_vld, timer[e_load_dst] is cleared to 0 (the wrong-path load is squashed).
  - flush_cnt_o increments.
- Idle (no stall, no flush): latch_en_f_o=1, all clears 0.
- Counters saturate at all-ones.
- Reset (asynchronous, also mid-stall or mid-flush):
  - All timers, e_load_vld, and both counters go to 0.
  - Outputs therefore read latch_en_f_o=1, clears 0, selects computed from the inputs.
  - The first cycle after reset cannot stall.
- Latency: forwarding, stall and flush outputs are same-cycle combinational. Scoreboard and counter updates are visible next cycle.

Test Plan:
1. Forwarding: rf_src0_e_i=5, rf_dst_m_i=5, rf_we_m_i=1, rf_dst_w_i=5, rf_we_w_i=1 -> sel0=1. Same with rf_we_m_i=0 -> sel0=2. Same with rf_src0_e_i=0 -> sel0=0.
2. LOAD_LAT=1: load to x3 issued; next cycle D has src0=3 -> exactly 1 cycle of latch_en_f_o=0 and latch_clear_d_o=1; stall_cnt_o=1; following cycle issues.
3. LOAD_LAT=2, same sequence -> 2 consecutive stall cycles, stall_cnt_o=2. Load to x0, or dependent with src1=3 and has_imm_d_i=1 -> no stall.
4. Load to x4 issued; next cycle pc_src_m_i=1 while D reads x4 -> all three clears=1, latch_en_f_o=1, flush_cnt_o=1, stall_cnt_o unchanged. Next cycle D reads x4 -> no stall.
5. Back-to-back loads to x5 then x6, with a dependent on x6 -> one stall; timer for x5 has already expired, so x5 contributes no extra stall.
6. Assert reset during a LOAD_LAT=2 stall -> outputs return to latch_en_f_o=1 immediately, counters 0; after release, D reading the pending register does not stall.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
// Hazard and pipeline-control unit for the 5-stage RISC-V core.
// - E-stage forwarding selects (M has priority over W).
// - Per-register countdown scoreboard for pending load writebacks, so the
//   load-use latency is set by LOAD_LAT instead of being fixed at one cycle.
// - Flush of the wrong-path F/D/E latches when a branch resolves taken in M.
// - Saturating stall and flush counters for performance analysis.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   rf_src0_d_i, rf_src1_d_i        D-stage source registers
//   has_imm_d_i                     D uses an immediate (src1 unused)
//   rf_dst_d_i, rf_we_d_i           D-stage destination and write enable
//   mem2rf_d_i                      D-stage instruction is a load
//   rf_src0_e_i, rf_src1_e_i        E-stage source registers
//   rf_dst_m_i, rf_we_m_i           M-stage destination and write enable
//   rf_dst_w_i, rf_we_w_i           W-stage destination and write enable
//   pc_src_m_i                      branch taken, resolved in M
//   alu_src0_sel_o, alu_src1_sel_o  E operand selects (0 RF, 1 M, 2 W)
//   latch_en_f_o                    enable for the PC and the F/D latch
//   latch_clear_f_o/_d_o/_e_o       clears for F/D, D/E and E/M latches
//   stall_cnt_o, flush_cnt_o        saturating performance counters
module hazard_ctrl_unit #(
  parameter int ADDR_W        = 5,
  parameter int ALU_SRC_SEL_W = 2,
  parameter int LOAD_LAT      = 1,
  parameter int CNT_W         = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        rf_src0_d_i,
  input  logic [ADDR_W-1:0]        rf_src1_d_i,
  input  logic                     has_imm_d_i,
  input  logic [ADDR_W-1:0]        rf_dst_d_i,
  input  logic                     rf_we_d_i,
  input  logic                     mem2rf_d_i,
  input  logic [ADDR_W-1:0]        rf_src0_e_i,
  input  logic [ADDR_W-1:0]        rf_src1_e_i,
  input  logic [ADDR_W-1:0]        rf_dst_m_i,
  input  logic                     rf_we_m_i,
  input  logic [ADDR_W-1:0]        rf_dst_w_i,
  input  logic                     rf_we_w_i,
  input  logic                     pc_src_m_i,
  output logic [ALU_SRC_SEL_W-1:0] alu_src0_sel_o,
  output logic [ALU_SRC_SEL_W-1:0] alu_src1_sel_o,
  output logic                     latch_en_f_o,
  output logic                     latch_clear_f_o,
  output logic                     latch_clear_d_o,
  output logic                     latch_clear_e_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic [CNT_W-1:0]         flush_cnt_o
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int TMR_W = $clog2(LOAD_LAT + 1);
  localparam logic [TMR_W-1:0]         TMR_LOAD = TMR_W'(LOAD_LAT);
  localparam logic [ALU_SRC_SEL_W-1:0] SEL_RF   = ALU_SRC_SEL_W'(0);
  localparam logic [ALU_SRC_SEL_W-1:0] SEL_M    = ALU_SRC_SEL_W'(1);
  localparam logic [ALU_SRC_SEL_W-1:0] SEL_W    = ALU_SRC_SEL_W'(2);

  // Remaining stall cycles per register; entry 0 is held at zero.
  logic [TMR_W-1:0]  timer [NREG];
  logic              e_load_vld;
  logic [ADDR_W-1:0] e_load_dst;

  logic src0_busy;
  logic src1_busy;
  logic stall;
  logic flush;
  logic issue;
  logic load_d;

  // Forwarding select for one E-stage source; M wins over W, x0 never forwards.
  function automatic logic [ALU_SRC_SEL_W-1:0] fwd_sel(
    input logic [ADDR_W-1:0] src,
    input logic [ADDR_W-1:0] dst_m,
    input logic              we_m,
    input logic [ADDR_W-1:0] dst_w,
    input logic              we_w
  );
    logic [ALU_SRC_SEL_W-1:0] sel;
    if ((src != ADDR_W'(0)) && we_m && (src == dst_m)) begin
      sel = SEL_M;
    end else if ((src != ADDR_W'(0)) && we_w && (src == dst_w)) begin
      sel = SEL_W;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Same-cycle forwarding, stall/flush decision and latch controls.
  always_comb begin
    alu_src0_sel_o  = fwd_sel(rf_src0_e_i, rf_dst_m_i, rf_we_m_i, rf_dst_w_i, rf_we_w_i);
    alu_src1_sel_o  = fwd_sel(rf_src1_e_i, rf_dst_m_i, rf_we_m_i, rf_dst_w_i, rf_we_w_i);
    src0_busy       = (rf_src0_d_i != ADDR_W'(0)) && (timer[rf_src0_d_i] != TMR_W'(0));
    src1_busy       = (rf_src1_d_i != ADDR_W'(0)) && (timer[rf_src1_d_i] != TMR_W'(0));
    stall           = src0_busy || (!has_imm_d_i && src1_busy);
    flush           = pc_src_m_i;
    issue           = !stall && !flush;
    load_d          = rf_we_d_i && mem2rf_d_i && (rf_dst_d_i != ADDR_W'(0));
    latch_en_f_o    = 1'b1;
    latch_clear_f_o = 1'b0;
    latch_clear_d_o = 1'b0;
    latch_clear_e_o = 1'b0;
    if (flush) begin
      // Flush overrides stall: fetch the branch target, squash F, D and E.
      latch_clear_f_o = 1'b1;
      latch_clear_d_o = 1'b1;
      latch_clear_e_o = 1'b1;
    end else if (stall) begin
      // Hold PC and F/D, inject a bubble into E.
      latch_en_f_o    = 1'b0;
      latch_clear_d_o = 1'b1;
    end else begin
      latch_en_f_o    = 1'b1;
    end
  end

  // Scoreboard timers: load on issue, squash the E-stage load on flush, else count down.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        timer[i] <= TMR_W'(0);
      end
    end else begin
      timer[0] <= TMR_W'(0);
      for (int i = 1; i < NREG; i++) begin
        if (issue && load_d && (rf_dst_d_i == ADDR_W'(i))) begin
          timer[i] <= TMR_LOAD;
        end else if (flush && e_load_vld && (e_load_dst == ADDR_W'(i))) begin
          timer[i] <= TMR_W'(0);
        end else if (timer[i] != TMR_W'(0)) begin
          timer[i] <= timer[i] - TMR_W'(1);
        end else begin
          timer[i] <= timer[i];
        end
      end
    end
  end

  // Tracks whether the instruction entering E is a scoreboarded load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_load_vld <= 1'b0;
      e_load_dst <= ADDR_W'(0);
    end else if (issue) begin
      e_load_vld <= load_d;
      e_load_dst <= rf_dst_d_i;
    end else begin
      e_load_vld <= 1'b0;
      e_load_dst <= e_load_dst;
    end
  end

  // Saturating performance counters; a flush cycle is never counted as a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_o <= CNT_W'(0);
      flush_cnt_o <= CNT_W'(0);
    end else begin
      if (stall && !flush && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end else begin
        stall_cnt_o <= stall_cnt_o;
      end
      if (flush && (flush_cnt_o != {CNT_W{1'b1}})) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end else begin
        flush_cnt_o <= flush_cnt_o;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit. Two instances share all inputs:
// u_dut1 (LOAD_LAT=1, 32-bit counters) and u_dut2 (LOAD_LAT=2, 4-bit
// counters so saturation is reachable). The reference model tracks, per
// register, the first cycle at which its pending load result is usable.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] src0_d, src1_d, dst_d, src0_e, src1_e, dst_m, dst_w;
  logic       imm_d, we_d, ld_d, we_m, we_w, pc_m;

  logic [1:0]  s0_1, s1_1, s0_2, s1_2;
  logic        en_1, cf_1, cd_1, ce_1, en_2, cf_2, cd_2, ce_2;
  logic [31:0] sc_1, fc_1;
  logic [3:0]  sc_2, fc_2;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.ADDR_W(5), .ALU_SRC_SEL_W(2), .LOAD_LAT(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .reset(reset),
    .rf_src0_d_i(src0_d), .rf_src1_d_i(src1_d), .has_imm_d_i(imm_d),
    .rf_dst_d_i(dst_d), .rf_we_d_i(we_d), .mem2rf_d_i(ld_d),
    .rf_src0_e_i(src0_e), .rf_src1_e_i(src1_e),
    .rf_dst_m_i(dst_m), .rf_we_m_i(we_m), .rf_dst_w_i(dst_w), .rf_we_w_i(we_w),
    .pc_src_m_i(pc_m),
    .alu_src0_sel_o(s0_1), .alu_src1_sel_o(s1_1),
    .latch_en_f_o(en_1), .latch_clear_f_o(cf_1), .latch_clear_d_o(cd_1),
    .latch_clear_e_o(ce_1), .stall_cnt_o(sc_1), .flush_cnt_o(fc_1)
  );

  hazard_ctrl_unit #(.ADDR_W(5), .ALU_SRC_SEL_W(2), .LOAD_LAT(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .reset(reset),
    .rf_src0_d_i(src0_d), .rf_src1_d_i(src1_d), .has_imm_d_i(imm_d),
    .rf_dst_d_i(dst_d), .rf_we_d_i(we_d), .mem2rf_d_i(ld_d),
    .rf_src0_e_i(src0_e), .rf_src1_e_i(src1_e),
    .rf_dst_m_i(dst_m), .rf_we_m_i(we_m), .rf_dst_w_i(dst_w), .rf_we_w_i(we_w),
    .pc_src_m_i(pc_m),
    .alu_src0_sel_o(s0_2), .alu_src1_sel_o(s1_2),
    .latch_en_f_o(en_2), .latch_clear_f_o(cf_2), .latch_clear_d_o(cd_2),
    .latch_clear_e_o(ce_2), .stall_cnt_o(sc_2), .flush_cnt_o(fc_2)
  );

  // Expected response for one cycle; ctl is {en_f, clear_f, clear_d, clear_e}.
  typedef struct {
    logic [1:0]  sel0;
    logic [1:0]  sel1;
    logic [3:0]  ctl1;
    logic [3:0]  ctl2;
    logic [31:0] scnt1;
    logic [31:0] fcnt1;
    logic [31:0] scnt2;
    logic [31:0] fcnt2;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model state, per latency configuration k (0: LAT 1, 1: LAT 2).
  int     avail [2][32];
  bit     e_vld [2];
  int     e_dst [2];
  longint scnt  [2];
  longint fcnt  [2];
  int     cyc = 0;
  int     lat   [2] = '{1, 2};
  longint cmax  [2] = '{64'd4294967295, 64'd15};

  function automatic logic [1:0] ref_fwd(input logic [4:0] s);
    if (s != 5'd0 && we_m && s == dst_m) return 2'd1;
    if (s != 5'd0 && we_w && s == dst_w) return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) avail[k][r] = 0;
      e_vld[k] = 1'b0;
      e_dst[k] = 0;
      scnt[k]  = 0;
      fcnt[k]  = 0;
    end
  endtask

  // Predict this cycle's outputs, push them, advance the model, then move one clock.
  task automatic step();
    exp_t       e;
    bit         st;
    logic [3:0] ctl;
    if (reset) model_clear();
    e.sel0 = ref_fwd(src0_e);
    e.sel1 = ref_fwd(src1_e);
    for (int k = 0; k < 2; k++) begin
      st = (src0_d != 5'd0 && cyc < avail[k][src0_d]) ||
           (!imm_d && src1_d != 5'd0 && cyc < avail[k][src1_d]);
      ctl = pc_m ? 4'b1111 : (st ? 4'b0010 : 4'b1000);
      if (k == 0) begin
        e.ctl1 = ctl; e.scnt1 = 32'(scnt[0]); e.fcnt1 = 32'(fcnt[0]);
      end else begin
        e.ctl2 = ctl; e.scnt2 = 32'(scnt[1]); e.fcnt2 = 32'(fcnt[1]);
      end
      if (!reset) begin
        if (pc_m) begin
          if (fcnt[k] < cmax[k]) fcnt[k]++;
          if (e_vld[k]) avail[k][e_dst[k]] = 0;
          e_vld[k] = 1'b0;
        end else if (st) begin
          if (scnt[k] < cmax[k]) scnt[k]++;
          e_vld[k] = 1'b0;
        end else begin
          e_vld[k] = we_d && ld_d && dst_d != 5'd0;
          e_dst[k] = dst_d;
          if (e_vld[k]) avail[k][dst_d] = cyc + 1 + lat[k];
        end
      end
    end
    exp_q.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int s0, input int s1, input bit im, input int d,
                       input bit we, input bit ld);
    src0_d = 5'(s0); src1_d = 5'(s1); imm_d = im;
    dst_d  = 5'(d);  we_d   = we;     ld_d  = ld;
  endtask

  task automatic set_ewm(input int se0, input int se1, input int dm, input bit wm,
                         input int dw, input bit ww);
    src0_e = 5'(se0); src1_e = 5'(se1);
    dst_m  = 5'(dm);  we_m   = wm;
    dst_w  = 5'(dw);  we_w   = ww;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
  endtask

  // Monitor: the DUT presents a response every cycle; compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sel0_lat1",  32'(s0_1), 32'(e.sel0));
      chk("sel1_lat1",  32'(s1_1), 32'(e.sel1));
      chk("sel0_lat2",  32'(s0_2), 32'(e.sel0));
      chk("sel1_lat2",  32'(s1_2), 32'(e.sel1));
      chk("ctl_lat1",   32'({en_1, cf_1, cd_1, ce_1}), 32'(e.ctl1));
      chk("ctl_lat2",   32'({en_2, cf_2, cd_2, ce_2}), 32'(e.ctl2));
      chk("stall_lat1", sc_1, e.scnt1);
      chk("flush_lat1", fc_1, e.fcnt1);
      chk("stall_lat2", 32'(sc_2), e.scnt2);
      chk("flush_lat2", 32'(fc_2), e.fcnt2);
    end
  end

  initial begin
    reset = 1'b1;
    pc_m  = 1'b0;
    set_d(0, 0, 0, 0, 0, 0);
    set_ewm(0, 0, 0, 0, 0, 0);
    model_clear();
    @(posedge clk);
    #1;
    step();
    step();
    reset = 1'b0;

    // Forwarding priority: M over W, x0 never forwarded.
    set_ewm(5, 5, 5, 1, 5, 1); step();
    set_ewm(5, 9, 5, 0, 5, 1); step();
    set_ewm(0, 5, 5, 1, 5, 1); step();
    set_ewm(0, 0, 0, 0, 0, 0);

    // Load to x3 then dependent on src0: 1 stall at LAT 1, 2 stalls at LAT 2.
    set_d(0, 0, 0, 3, 1, 1); step();
    set_d(3, 0, 0, 7, 1, 0); step(); step(); step();
    set_d(0, 0, 0, 0, 0, 0); step(); step();

    // Load to x0 never stalls; immediate user of x3 via src1 never stalls.
    set_d(0, 0, 0, 0, 1, 1); step();
    set_d(0, 0, 0, 8, 1, 0); step();
    set_d(0, 0, 0, 3, 1, 1); step();
    set_d(0, 3, 1, 8, 1, 0); step();
    set_d(0, 0, 0, 0, 0, 0); step(); step();

    // Flush while load to x4 sits in E squashes its scoreboard entry.
    set_d(0, 0, 0, 4, 1, 1); step();
    set_d(4, 0, 0, 9, 1, 0); pc_m = 1'b1; step();
    pc_m = 1'b0; step();
    set_d(0, 0, 0, 0, 0, 0); step();

    // Back-to-back loads to x5 and x6, then a user of both.
    set_d(0, 0, 0, 5, 1, 1); step();
    set_d(0, 0, 0, 6, 1, 1); step();
    set_d(6, 5, 0, 10, 1, 0); step(); step(); step();
    set_d(0, 0, 0, 0, 0, 0); step(); step();

    // Reset during a LAT 2 stall; the pending register is free afterwards.
    set_d(0, 0, 0, 3, 1, 1); step();
    set_d(3, 0, 0, 11, 1, 0); step();
    reset = 1'b1; step();
    reset = 1'b0; step(); step();
    set_d(0, 0, 0, 0, 0, 0); step();

    // Randomised traffic over a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      set_d($urandom_range(0, 7), $urandom_range(0, 7), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 7), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
      set_ewm($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              ($urandom_range(0, 1) == 1), $urandom_range(0, 7), ($urandom_range(0, 1) == 1));
      pc_m = ($urandom_range(0, 7) == 0);
      step();
    end
    pc_m = 1'b0;

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
